comparador_serial_izq_der: RTL and testbench
============================================

Name: comparador_serial_izq_der

Overview:
- Sequential, parametrised successor to the combinational left-to-right iterative comparator network.
- One iterative cell is reused in time. It scans operand words A and B MSB-first, one bit per clock, and tracks the comparison state {p,q}.
- After the last bit it produces the relation output Zout, selected at run time from four comparison modes.
- Sits beside the combinational network as the area-saving variant for wide words, with a start/busy/done handshake.

Parameters:
- WIDTH, 8: operand width in bits; legal range 2..64.
- IDXW, $clog2(WIDTH): width of the internal bit-index counter; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a comparison; sampled only in IDLE.
- A  input  WIDTH  operand A; captured on accepted start.
- B  input  WIDTH  operand B; captured on accepted start.
- modo  input  2  relation select, captured on accepted start: 00 A==B, 01 A>B, 10 A<B, 11 A>=B.
- busy  output  1  high while a comparison is in progress.
- done  output  1  one-cycle pulse: result valid.
- pout  output  1  comparison state bit p.
- qout  output  1  comparison state bit q.
- Zout  output  1  relation result for the captured modo.

Behaviour:
- Comparison state encoding {p,q}:
  - 00 none (reset/idle, no result yet).
  - 01 a: equal so far.
  - 10 b: A>B decided.
  - 11 c: A<B decided.
- Control FSM states: IDLE, SCAN, FIN.
- Reset (async, rst_n=0): FSM=IDLE, {p,q}=00, Zout=0, busy=0, done=0, index=0. The operand and mode registers clear to 0. Reset mid-SCAN aborts immediately; no done pulse follows.
- IDLE:
  - On start=1: capture A, B, modo into registers; {p,q}<=01; index<=WIDTH-1; go SCAN.
  - Previous {p,q} and Zout hold until this accepted start.
- SCAN: busy=1. Each cycle, evaluate bits Ar[index], Br[index]:
  - If {p,q}=01 and Ar>Br: go to 10.
  - If {p,q}=01 and Ar<Br: go to 11.
  - Otherwise hold. States 10 and 11 are absorbing.
  - If index==0: go FIN. Otherwise decrement index.
- FIN:
  - Zout <= f(modo, {p,q}): 00 → (pq==01); 01 → (pq==10); 10 → (pq==11); 11 → (pq==01 | pq==10).
  - done=1 for exactly this one cycle; busy=0; next state IDLE.
  - pout/qout/Zout then hold until the next accepted start.
- Latency: with start accepted at edge 0, done is high in the cycle after edge WIDTH+1 (WIDTH SCAN cycles + 1 FIN cycle).
- Start while busy or in FIN is ignored, not queued. Start held high continuously launches back-to-back comparisons, one every WIDTH+2 cycles.
- A, B, modo changes after capture have no effect on the running comparison.
- pout/qout show the live {p,q} during SCAN. They are not guaranteed final until done.
- Zout changes only in FIN and on reset.

Optional Feature:
- Macro: COMPARADOR_SALIDA_TEMPRANA_EN.
- Defined: in SCAN, when {p,q} becomes 10 or 11, the FSM goes to FIN on the next edge without scanning remaining bits. Latency becomes (k+1)+1 cycles, where k is the number of leading equal bits. Equal operands still take WIDTH+1 cycles.
- Undefined: always the full WIDTH scan; latency is fixed at WIDTH+1 cycles.

Test Plan (WIDTH=8):
- Equality: A=8'hA5, B=8'hA5, modo=00, start 1 cycle → done after 9 cycles; {pout,qout}=01, Zout=1. Repeat with modo=11 → Zout=1.
- MSB decides A>B: A=8'h80, B=8'h7F, modo=01 → {p,q}=10 from the first SCAN cycle and stays 10; Zout=1. With macro defined, done 2 cycles after start, not 9.
- LSB decides A<B: A=8'h10, B=8'h11, modo=10 → {p,q}=01 for 7 SCAN cycles, then 11; Zout=1. Rerun with modo=11 → Zout=0.
- Exhaustive 2-bit sweep (WIDTH=2 build): all 16 A/B pairs × 4 modo values → Zout matches the reference relation on every done pulse; each done lasts exactly 1 cycle.
- Handshake: start asserted again mid-SCAN with new A/B → ignored, and the first result is unchanged. Start held high → done pulses every 10 cycles, each with correct Zout for the operands captured at its start.
- Reset mid-SCAN: rst_n low for 1 ns asynchronously at the 4th SCAN cycle → busy, done, pout, qout, Zout go to 0 immediately; no done pulse; the next start completes normally.

Source files
------------

// File: rtl/comparador_serial_izq_der.sv
// -----------------------------------------------------------------------------
// comparador_serial_izq_der
// Bit-serial magnitude comparator. A single left-to-right iterative cell is
// reused in time: operands A and B are scanned MSB-first, one bit per clock,
// while the comparison state {p,q} is tracked. After the scan, the relation
// selected by modo is registered on Zout and done pulses for one cycle.
//
// {p,q} encoding: 00 none, 01 equal so far, 10 A>B, 11 A<B.
// modo: 00 A==B, 01 A>B, 10 A<B, 11 A>=B.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   comparison request, sampled only while idle
//   A, B   in   WIDTH-bit operands, captured on accepted start
//   modo   in   2-bit relation select, captured on accepted start
//   busy   out  high while scanning bits
//   done   out  one-cycle pulse, Zout/pout/qout valid
//   pout   out  comparison state bit p
//   qout   out  comparison state bit q
//   Zout   out  relation result for the captured modo
//
// Optional build macro: COMPARADOR_SALIDA_TEMPRANA_EN
//   When defined, the scan stops as soon as the relation is decided
//   (first differing bit) instead of walking every remaining bit.
// -----------------------------------------------------------------------------
module comparador_serial_izq_der #(
    parameter  int WIDTH = 8,
    localparam int IDXW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       modo,
    output logic             busy,
    output logic             done,
    output logic             pout,
    output logic             qout,
    output logic             Zout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        FIN  = 2'd2
    } estado_t;

    localparam logic [1:0] PQ_NONE = 2'b00;
    localparam logic [1:0] PQ_EQ   = 2'b01;
    localparam logic [1:0] PQ_GT   = 2'b10;
    localparam logic [1:0] PQ_LT   = 2'b11;

    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(WIDTH - 1);

    // Relation selected by modo, evaluated on the final {p,q}.
    function automatic logic f_relacion(input logic [1:0] m, input logic [1:0] pq);
        logic r;
        case (m)
            2'b00:   r = (pq == PQ_EQ);
            2'b01:   r = (pq == PQ_GT);
            2'b10:   r = (pq == PQ_LT);
            2'b11:   r = (pq == PQ_EQ) || (pq == PQ_GT);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    estado_t          state_q, state_d;
    logic [1:0]       pq_q, pq_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       modo_q, modo_d;
    logic             zout_q, zout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             bit_a_s, bit_b_s;

    // Next-state, datapath and output decode.
    always_comb begin
        state_d = state_q;
        pq_d    = pq_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        modo_d  = modo_q;
        zout_d  = zout_q;
        bit_a_s = 1'b0;
        bit_b_s = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = B;
                    modo_d  = modo;
                    pq_d    = PQ_EQ;
                    idx_d   = IDX_LAST;
                    state_d = SCAN;
                end else begin
                    state_d = IDLE;
                end
            end
            SCAN: begin
                bit_a_s = a_q[idx_q];
                bit_b_s = b_q[idx_q];
                // Only the "equal so far" state can move; decided states absorb.
                if ((pq_q == PQ_EQ) && bit_a_s && !bit_b_s) begin
                    pq_d = PQ_GT;
                end else if ((pq_q == PQ_EQ) && !bit_a_s && bit_b_s) begin
                    pq_d = PQ_LT;
                end else begin
                    pq_d = pq_q;
                end
                if (idx_q == '0) begin
                    state_d = FIN;
                end else begin
                    idx_d   = idx_q - IDXW'(1);
                    state_d = SCAN;
                end
`ifdef COMPARADOR_SALIDA_TEMPRANA_EN
                // Once decided, remaining bits cannot change the outcome.
                if ((pq_d == PQ_GT) || (pq_d == PQ_LT)) begin
                    state_d = FIN;
                end else begin
                    state_d = state_d;
                end
`endif
            end
            FIN: begin
                zout_d  = f_relacion(modo_q, pq_q);
                idx_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered status: busy tracks the scan, done follows the FIN cycle
        // so it lines up with the freshly registered Zout.
        busy_d = (state_d == SCAN);
        done_d = (state_q == FIN);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pq_q    <= PQ_NONE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            modo_q  <= 2'b00;
            zout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pq_q    <= pq_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            modo_q  <= modo_d;
            zout_q  <= zout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign pout = pq_q[1];
    assign qout = pq_q[0];
    assign Zout = zout_q;

endmodule

// File: tb/tb_comparador_serial_izq_der.sv
// -----------------------------------------------------------------------------
// Testbench for comparador_serial_izq_der: a WIDTH=8 instance for directed
// vectors, handshake and reset cases, and a WIDTH=2 instance for an
// exhaustive operand/mode sweep against a reference relation.
// -----------------------------------------------------------------------------
module tb_comparador_serial_izq_der;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = 8'h00;
    logic [7:0] b8 = 8'h00;
    logic [1:0] modo8 = 2'b00;
    logic       busy8, done8, pout8, qout8, zout8;

    logic       start2 = 1'b0;
    logic [1:0] a2 = 2'b00;
    logic [1:0] b2 = 2'b00;
    logic [1:0] modo2 = 2'b00;
    logic       busy2, done2, pout2, qout2, zout2;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int t0 = 0;
    int lat = 0;

    comparador_serial_izq_der #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .modo(modo8),
        .busy(busy8), .done(done8), .pout(pout8), .qout(qout8), .Zout(zout8)
    );

    comparador_serial_izq_der #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .A(a2), .B(b2), .modo(modo2),
        .busy(busy2), .done(done2), .pout(pout2), .qout(qout2), .Zout(zout2)
    );

    always #5 clk = ~clk;

    // Edge counter used to measure latency from the accepting edge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_rel(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m);
        case (m)
            2'b00:   return a == b;
            2'b01:   return a > b;
            2'b10:   return a < b;
            default: return a >= b;
        endcase
    endfunction

    // Expected cycles from accepting edge to the edge that raises done.
    function automatic int exp_lat8(input logic [7:0] a, input logic [7:0] b);
        int l;
        l = 9;
        for (int i = 7; i >= 0; i--) begin
            if ((a[i] != b[i]) && (l == 9)) l = 9 - i;
        end
`ifdef COMPARADOR_SALIDA_TEMPRANA_EN
        return l;
`else
        l = 9;
        return l;
`endif
    endfunction

    // Launch one comparison on the 8-bit instance; returns at the negedge after edge 0.
    task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m);
        @(negedge clk);
        a8 = a; b8 = b; modo8 = m; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done8(input string tag);
        int n;
        n = 0;
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_timeout"}, {31'd0, done8}, 32'd1);
        lat = cyc - t0;
    endtask

    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] m, input logic [1:0] exp_pq, input logic exp_z);
        go8(a, b, m);
        wait_done8(tag);
        chk({tag, "_lat"}, lat, exp_lat8(a, b));
        chk({tag, "_pq"}, {30'd0, pout8, qout8}, {30'd0, exp_pq});
        chk({tag, "_z"}, {31'd0, zout8}, {31'd0, exp_z});
        @(negedge clk);
        chk({tag, "_done1"}, {31'd0, done8}, 32'd0);
    endtask

    logic [7:0] ha [0:2];
    logic [7:0] hb [0:2];
    logic [1:0] hm [0:2];
    int tprev;
    int ndone;

    initial begin
        // Reset state
        #3;
        chk("rst_busy", {31'd0, busy8}, 32'd0);
        chk("rst_done", {31'd0, done8}, 32'd0);
        chk("rst_pq", {30'd0, pout8, qout8}, 32'd0);
        chk("rst_z", {31'd0, zout8}, 32'd0);
        #9 rst_n = 1'b1;

        // Equality under both equality-including modes
        run8("eq_m00", 8'hA5, 8'hA5, 2'b00, 2'b01, 1'b1);
        run8("eq_m11", 8'hA5, 8'hA5, 2'b11, 2'b01, 1'b1);

        // MSB decides A>B: state is 10 right after the first scan edge
        go8(8'h80, 8'h7F, 2'b01);
        @(negedge clk);
        chk("msb_pq_e1", {30'd0, pout8, qout8}, 32'd2);
        wait_done8("msb");
        chk("msb_lat", lat, exp_lat8(8'h80, 8'h7F));
        chk("msb_pq", {30'd0, pout8, qout8}, 32'd2);
        chk("msb_z", {31'd0, zout8}, 32'd1);

        // LSB decides A<B: equal for 7 scan edges, then 11
        go8(8'h10, 8'h11, 2'b10);
        chk("lsb_busy", {31'd0, busy8}, 32'd1);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            chk($sformatf("lsb_pq_e%0d", i), {30'd0, pout8, qout8}, 32'd1);
        end
        @(negedge clk);
        chk("lsb_pq_e8", {30'd0, pout8, qout8}, 32'd3);
        wait_done8("lsb");
        chk("lsb_lat", lat, 9);
        chk("lsb_z", {31'd0, zout8}, 32'd1);
        @(negedge clk);
        run8("lsb_m11", 8'h10, 8'h11, 2'b11, 2'b11, 1'b0);

        // Start mid-scan with new operands is ignored
        go8(8'h01, 8'h02, 2'b10);
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h00; modo8 = 2'b01; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8("ign");
        chk("ign_lat", lat, exp_lat8(8'h01, 8'h02));
        chk("ign_pq", {30'd0, pout8, qout8}, 32'd3);
        chk("ign_z", {31'd0, zout8}, 32'd1);
        @(negedge clk);
        chk("ign_done1", {31'd0, done8}, 32'd0);
        repeat (3) @(negedge clk);
        chk("ign_idle_busy", {31'd0, busy8}, 32'd0);

        // Start held high: back-to-back comparisons
        ha[0] = 8'h55; hb[0] = 8'h55; hm[0] = 2'b00;
        ha[1] = 8'h40; hb[1] = 8'h41; hm[1] = 2'b01;
        ha[2] = 8'hC3; hb[2] = 8'h3C; hm[2] = 2'b11;
        @(negedge clk);
        a8 = ha[0]; b8 = hb[0]; modo8 = hm[0]; start8 = 1'b1;
        @(negedge clk);
        t0 = cyc;
        a8 = ha[1]; b8 = hb[1]; modo8 = hm[1];
        tprev = 0;
        for (int k = 0; k < 3; k++) begin
            ndone = 0;
            while (!done8 && ndone < 40) begin
                @(negedge clk);
                ndone++;
            end
            chk($sformatf("hold%0d_timeout", k), {31'd0, done8}, 32'd1);
            if (k == 2) start8 = 1'b0;
            chk($sformatf("hold%0d_z", k), {31'd0, zout8}, {31'd0, ref_rel(ha[k], hb[k], hm[k])});
            if (k > 0) chk($sformatf("hold%0d_period", k), cyc - tprev, exp_lat8(ha[k], hb[k]) + 1);
            else chk("hold0_lat", cyc - t0, exp_lat8(ha[0], hb[0]));
            tprev = cyc;
            @(negedge clk);
            if (k == 0) begin
                a8 = ha[2]; b8 = hb[2]; modo8 = hm[2];
            end
        end
        repeat (2) @(negedge clk);

        // Asynchronous reset in the 4th scan cycle
        go8(8'h01, 8'h00, 2'b01);
        repeat (3) @(negedge clk);
        chk("rst_mid_busy_pre", {31'd0, busy8}, 32'd1);
        #1 rst_n = 1'b0;
        #0.5;
        chk("rstm_busy", {31'd0, busy8}, 32'd0);
        chk("rstm_done", {31'd0, done8}, 32'd0);
        chk("rstm_pq", {30'd0, pout8, qout8}, 32'd0);
        chk("rstm_z", {31'd0, zout8}, 32'd0);
        #0.5 rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8) ndone++;
        end
        chk("rstm_no_done", ndone, 0);
        run8("post_rst", 8'h01, 8'h00, 2'b01, 2'b10, 1'b1);

        // Exhaustive 2-bit sweep
        for (int m = 0; m < 4; m++) begin
            for (int a = 0; a < 4; a++) begin
                for (int b = 0; b < 4; b++) begin
                    @(negedge clk);
                    a2 = 2'(a); b2 = 2'(b); modo2 = 2'(m); start2 = 1'b1;
                    @(negedge clk);
                    start2 = 1'b0;
                    ndone = 0;
                    while (!done2 && ndone < 20) begin
                        @(negedge clk);
                        ndone++;
                    end
                    chk($sformatf("w2_timeout_a%0d_b%0d_m%0d", a, b, m), {31'd0, done2}, 32'd1);
                    chk($sformatf("w2_z_a%0d_b%0d_m%0d", a, b, m), {31'd0, zout2},
                        {31'd0, ref_rel(8'(a), 8'(b), 2'(m))});
                    @(negedge clk);
                    chk($sformatf("w2_done1_a%0d_b%0d_m%0d", a, b, m), {31'd0, done2}, 32'd0);
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
